vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen_if.sv | 42 ++++
 rtl/vga_timing_gen.sv | 164 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel enable and run request in, timing and
// coordinate outputs back. The generator is the master (drives the raster
// outputs); the pixel pipeline side is the slave (drives i_ce / i_en).
//
// Handshake: there is no valid/ready pair. i_ce qualifies every PIXELCLK
// edge; state and level outputs move only on edges where i_ce=1, strobes
// (o_line_start / o_frame_start) are valid for exactly the one PIXELCLK cycle
// after the i_ce edge that produced them, and o_busy mirrors the run state.
interface vga_timing_gen_if #(
    parameter int CNT_W   = 12,
    parameter int FRAME_W = 8
);
    logic               i_ce;
    logic               i_en;
    logic               o_hs;
    logic               o_vs;
    logic               o_de;
    logic [CNT_W-1:0]   o_h_cnt;
    logic [CNT_W-1:0]   o_v_cnt;
    logic [CNT_W-1:0]   o_x;
    logic [CNT_W-1:0]   o_y;
    logic               o_line_start;
    logic               o_frame_start;
    logic               o_vblank;
    logic [FRAME_W-1:0] o_frame_cnt;
    logic               o_busy;
    logic [1:0]         o_state;

    modport master (
        input  i_ce, i_en,
        output o_hs, o_vs, o_de, o_h_cnt, o_v_cnt, o_x, o_y,
               o_line_start, o_frame_start, o_vblank, o_frame_cnt,
               o_busy, o_state
    );

    modport slave (
        output i_ce, i_en,
        input  o_hs, o_vs, o_de, o_h_cnt, o_v_cnt, o_x, o_y,
               o_line_start, o_frame_start, o_vblank, o_frame_cnt,
               o_busy, o_state
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator. A free-running h/v counter
// pair walks the full raster while running; a registered output stage
// presents the decode of the counter position so every output describes the
// same (o_h_cnt, o_v_cnt). Starting takes one i_ce in IDLE; stopping is
// deferred to the end of the current frame so no line is ever cut short.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 12,
    parameter int FRAME_W  = 8
) (
    input  logic            PIXELCLK,
    input  logic            i_rstn,
    vga_timing_gen_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] ZERO_C     = '0;

    // Run states; STOP_PENDING keeps counting until the frame wraps.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;

    logic running;
    logic h_last;
    logic v_last;
    logic at_wrap;
    logic de_d;
    logic hs_act;
    logic vs_act;
    logic vblank_d;
    logic line_d;
    logic frame_d;

    // Position decode of the counters that the output stage will present.
    always_comb begin
        running  = (state == S_RUN) || (state == S_STOP);
        h_last   = (h == H_LAST);
        v_last   = (v == V_LAST);
        at_wrap  = h_last && v_last;
        de_d     = (h < H_ACT_C) && (v < V_ACT_C);
        hs_act   = (h >= HS_START) && (h < HS_END);
        vs_act   = (v >= VS_START) && (v < VS_END);
        vblank_d = (v >= V_ACT_C);
        line_d   = (h == ZERO_C);
        frame_d  = (h == ZERO_C) && (v == ZERO_C);
    end

    // Run-state machine and raster counters; everything advances only on i_ce.
    always_ff @(posedge PIXELCLK) begin
        if (!i_rstn) begin
            state <= S_IDLE;
            h     <= '0;
            v     <= '0;
        end else if (bus.i_ce) begin
            case (state)
                S_IDLE: begin
                    h <= '0;
                    v <= '0;
                    if (bus.i_en) begin
                        state <= S_RUN;
                    end
                end
                S_RUN, S_STOP: begin
                    if (h_last) begin
                        h <= '0;
                        v <= v_last ? '0 : v + 1'b1;
                    end else begin
                        h <= h + 1'b1;
                    end
                    // A renewed run request always wins; otherwise a pending
                    // stop only lands on the frame wrap.
                    if (bus.i_en) begin
                        state <= S_RUN;
                    end else if ((state == S_STOP) && at_wrap) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_STOP;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    h     <= '0;
                    v     <= '0;
                end
            endcase
        end
    end

    // Registered output stage: decoded position while running, idle levels
    // otherwise; strobes drop on any cycle without i_ce.
    always_ff @(posedge PIXELCLK) begin
        if (!i_rstn) begin
            bus.o_hs          <= ~HS_POL;
            bus.o_vs          <= ~VS_POL;
            bus.o_de          <= 1'b0;
            bus.o_h_cnt       <= '0;
            bus.o_v_cnt       <= '0;
            bus.o_x           <= '0;
            bus.o_y           <= '0;
            bus.o_line_start  <= 1'b0;
            bus.o_frame_start <= 1'b0;
            bus.o_vblank      <= 1'b0;
            bus.o_frame_cnt   <= '0;
        end else if (bus.i_ce) begin
            if (running) begin
                bus.o_hs          <= hs_act ? HS_POL : ~HS_POL;
                bus.o_vs          <= vs_act ? VS_POL : ~VS_POL;
                bus.o_de          <= de_d;
                bus.o_h_cnt       <= h;
                bus.o_v_cnt       <= v;
                bus.o_x           <= de_d ? h : '0;
                bus.o_y           <= de_d ? v : '0;
                bus.o_line_start  <= line_d;
                bus.o_frame_start <= frame_d;
                bus.o_vblank      <= vblank_d;
                if (frame_d) begin
                    bus.o_frame_cnt <= bus.o_frame_cnt + 1'b1;
                end
            end else begin
                bus.o_hs          <= ~HS_POL;
                bus.o_vs          <= ~VS_POL;
                bus.o_de          <= 1'b0;
                bus.o_h_cnt       <= '0;
                bus.o_v_cnt       <= '0;
                bus.o_x           <= '0;
                bus.o_y           <= '0;
                bus.o_line_start  <= 1'b0;
                bus.o_frame_start <= 1'b0;
                bus.o_vblank      <= 1'b0;
            end
        end else begin
            bus.o_line_start  <= 1'b0;
            bus.o_frame_start <= 1'b0;
        end
    end

    assign bus.o_busy  = (state != S_IDLE);
    assign bus.o_state = state;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. A small raster (14 x 7, active-high syncs) is
// checked cycle by cycle against a raster model through an expected queue;
// a default-parameter instance shares the stimulus and gets directed checks
// on its first line and on its active-low idle levels.
module tb_vga_timing_gen;

    localparam int CW = 12;
    localparam int FW = 8;
    localparam int S_HT = 14;   // 8 + 2 + 3 + 1
    localparam int S_FT = 98;   // 14 * (4 + 1 + 1 + 1)

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic ce = 1'b0;
    logic en = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [62:0] exp_q[$];

    vga_timing_gen_if #(.CNT_W(CW), .FRAME_W(FW)) bs ();
    vga_timing_gen_if #(.CNT_W(CW), .FRAME_W(FW)) bd ();

    assign bs.i_ce = ce;
    assign bs.i_en = en;
    assign bd.i_ce = ce;
    assign bd.i_en = en;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(CW), .FRAME_W(FW)
    ) dut_s (
        .PIXELCLK(clk),
        .i_rstn  (rstn),
        .bus     (bs)
    );

    vga_timing_gen #(.CNT_W(CW), .FRAME_W(FW)) dut_d (
        .PIXELCLK(clk),
        .i_rstn  (rstn),
        .bus     (bd)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [62:0] pack(
        input logic busy, input logic hs, input logic vs, input logic de,
        input logic ls, input logic fs, input logic vb,
        input logic [CW-1:0] h, input logic [CW-1:0] v,
        input logic [CW-1:0] x, input logic [CW-1:0] y,
        input logic [FW-1:0] fc
    );
        return {busy, hs, vs, de, ls, fs, vb, h, v, x, y, fc};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // Raster model of the small instance.
    int  m_mode = 0;    // 0 idle, 1 run, 2 stop pending
    int  m_p = 0;       // next linear raster position to present
    logic e_hs, e_vs, e_de, e_ls, e_fs, e_vb;
    int  e_h, e_v;
    logic [FW-1:0] e_fc = '0;

    task automatic model_idle();
        e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
        e_vb = 1'b0; e_h = 0; e_v = 0;
    endtask

    task automatic model_edge(input logic c, input logic e, input logic r);
        if (!r) begin
            m_mode = 0; m_p = 0; e_fc = '0;
            model_idle();
        end else if (c) begin
            if (m_mode == 0) begin
                model_idle();
                if (e) m_mode = 1;
            end else begin
                e_h  = m_p % S_HT;
                e_v  = m_p / S_HT;
                e_de = (e_h < 8) && (e_v < 4);
                e_hs = (e_h >= 10) && (e_h <= 12);
                e_vs = (e_v == 5);
                e_ls = (e_h == 0);
                e_fs = (m_p == 0);
                e_vb = (e_v >= 4);
                if (e_fs) e_fc = e_fc + 1'b1;
                if (m_p == S_FT - 1) begin
                    m_p = 0;
                    if (!e && m_mode == 2) m_mode = 0;
                    else m_mode = e ? 1 : 2;
                end else begin
                    m_p = m_p + 1;
                    m_mode = e ? 1 : 2;
                end
            end
        end else begin
            e_ls = 1'b0;
            e_fs = 1'b0;
        end
    endtask

    // Driver: apply one cycle of inputs, then queue the expected response.
    task automatic step(input logic c, input logic e, input logic r);
        logic [CW-1:0] xh, yv;
        ce = c; en = e; rstn = r;
        @(posedge clk);
        model_edge(c, e, r);
        xh = e_de ? CW'(e_h) : '0;
        yv = e_de ? CW'(e_v) : '0;
        exp_q.push_back(pack(m_mode != 0, e_hs, e_vs, e_de, e_ls, e_fs, e_vb,
                             CW'(e_h), CW'(e_v), xh, yv, e_fc));
        #1;
    endtask

    // Monitor: every cycle the small instance presents a raster state.
    always @(negedge clk) begin
        logic [62:0] act, req;
        if (exp_q.size() > 0) begin
            req = exp_q.pop_front();
            act = pack(bs.o_busy, bs.o_hs, bs.o_vs, bs.o_de, bs.o_line_start,
                       bs.o_frame_start, bs.o_vblank, bs.o_h_cnt, bs.o_v_cnt,
                       bs.o_x, bs.o_y, bs.o_frame_cnt);
            check("raster", {1'b0, act}, {1'b0, req});
        end
    end

    initial begin
        int fs_a, fs_b;
        int d_de_cnt, d_hs_cnt, d_hs_min, d_hs_max, d_vs_low;

        // Reset, including a cycle without i_ce.
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("reset_busy", {63'd0, bs.o_busy}, 64'd0);
        check("reset_d_hs_vs", {62'd0, bd.o_hs, bd.o_vs}, 64'd3);
        check("reset_d_cnt", {40'd0, bd.o_h_cnt, bd.o_v_cnt}, 64'd0);

        // Start with i_ce tied high; both instances run from the same edge.
        step(1'b1, 1'b1, 1'b1);
        check("start_busy", {63'd0, bd.o_busy}, 64'd1);
        check("start_idle_out", {62'd0, bd.o_de, bd.o_frame_start}, 64'd0);
        step(1'b1, 1'b1, 1'b1);
        check("first_fs", {61'd0, bd.o_frame_start, bd.o_line_start, bd.o_de}, 64'd7);
        check("first_pos", {40'd0, bd.o_h_cnt, bd.o_v_cnt}, 64'd0);
        check("first_fcnt", {56'd0, bd.o_frame_cnt}, 64'd1);

        fs_a = -1; fs_b = -1;
        d_de_cnt = 0; d_hs_cnt = 0; d_hs_min = 9999; d_hs_max = -1; d_vs_low = 0;
        if (bd.o_v_cnt == 0 && bd.o_de) d_de_cnt++;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'b1, 1'b1);
            if (bs.o_frame_start) begin
                if (fs_a < 0) fs_a = cyc;
                else if (fs_b < 0) fs_b = cyc;
            end
            if (bd.o_v_cnt == 0 && bd.o_busy) begin
                if (bd.o_de) d_de_cnt++;
                if (!bd.o_vs) d_vs_low++;
                if (!bd.o_hs) begin
                    d_hs_cnt++;
                    if (int'(bd.o_h_cnt) < d_hs_min) d_hs_min = int'(bd.o_h_cnt);
                    if (int'(bd.o_h_cnt) > d_hs_max) d_hs_max = int'(bd.o_h_cnt);
                end
            end
        end
        check("frame_period", 64'(fs_b - fs_a), 64'd98);
        check("d_line0_de", 64'(d_de_cnt), 64'd640);
        check("d_hs_width", 64'(d_hs_cnt), 64'd96);
        check("d_hs_first", 64'(d_hs_min), 64'd656);
        check("d_hs_last", 64'(d_hs_max), 64'd751);
        check("d_vs_line0", 64'(d_vs_low), 64'd0);

        // i_ce every second cycle: periods double, strobes stay one cycle.
        fs_a = -1; fs_b = -1;
        for (int i = 0; i < 450; i++) begin
            step(i[0], 1'b1, 1'b1);
            if (bs.o_frame_start) begin
                if (fs_a < 0) fs_a = cyc;
                else if (fs_b < 0) fs_b = cyc;
            end
        end
        check("frame_period_half_ce", 64'(fs_b - fs_a), 64'd196);

        // Graceful stop: run on to the end of the frame, then idle.
        for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b1);
        check("stop_busy", {63'd0, bs.o_busy}, 64'd0);
        check("stop_idle_pos", {40'd0, bs.o_h_cnt, bs.o_v_cnt}, 64'd0);

        // Restart, drop i_en mid-frame and raise it again before the wrap.
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 150; i++) step(1'b1, 1'b1, 1'b1);
        check("resume_busy", {63'd0, bs.o_busy}, 64'd1);

        // Mid-frame reset, then restart from (0,0).
        for (int i = 0; i < 37; i++) step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        check("midreset_fcnt", {56'd0, bs.o_frame_cnt}, 64'd0);
        for (int i = 0; i < 120; i++) step(1'b1, 1'b1, 1'b1);

        // Irregular enable / run / occasional reset patterns.
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 299) != 0));
        end

        @(negedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
